miner_core_compress: RTL and testbench
======================================

MINER_CORE_COMPRESS -- requirements
Module: miner_core_compress

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk and n_rst.
REQ-002 SHALL have parameter ROUNDS, default 64, meaning the number of SHA-256 rounds per block; only the value 64 is supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to compress one block; sampled only in IDLE.
REQ-006 w  input  [0:63][0:31]  expanded message schedule from miner_core_msa; bit 0 is the MSB.
REQ-007 hash_in  input  [0:7][0:31]  chaining value H0..H7, either the initial values or the previous block's digest.
REQ-008 busy  output  1  high from start acceptance until the final-add edge.
REQ-009 done  output  1  one-cycle pulse; hash_out is valid from this pulse onward.
REQ-010 hash_out  output  [0:7][0:31]  resulting digest H0'..H7'.

Function
REQ-011 SHALL implement the FSM states IDLE, ROUND, FINAL and DONE.
REQ-012 IDLE with start=1 at edge E0 SHALL:
- load a..h and an internal h_save copy from hash_in;
- clear the round counter t to 0;
- set busy=1 and go to ROUND.
REQ-013 Each ROUND edge SHALL execute one SHA-256 round using w[t] and K[t], then increment t (7-bit counter).
REQ-014 Round arithmetic SHALL be:
- T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + w[t];
- T2 = Sigma0(a) + Maj(a,b,c);
- all sums modulo 2^32.
REQ-015 Sigma0 SHALL be ROTR2^ROTR13^ROTR22, and Sigma1 SHALL be ROTR6^ROTR11^ROTR25.
REQ-016 On the round with t=63 (edge E64), the FSM SHALL go to FINAL.
REQ-017 At the FINAL edge (E65), the block SHALL:
- register hash_out[i] = h_save[i] + working register i (mod 2^32) for i = 0..7;
- set done=1 and busy=0;
- go to DONE.
REQ-018 At the DONE edge (E66), done SHALL return to 0 and the FSM SHALL return to IDLE.
REQ-019 A new start SHALL be accepted no earlier than E67, giving a throughput of 67 cycles per block.
REQ-020 start while busy=1, in FINAL or in DONE SHALL be ignored with no queuing.
REQ-021 hash_out SHALL hold its value until the next FINAL edge or reset.
REQ-022 w SHALL be sampled live each round; the upstream block must hold w stable from E0 through E64. hash_in SHALL be sampled only at E0.
REQ-023 In the back-to-back case, hash_in may be driven from hash_out directly (chaining).

Reset
REQ-024 n_rst low SHALL asynchronously force:
- the FSM to IDLE and t to 0;
- busy=0 and done=0;
- hash_out, a..h and h_save to all zeros.
REQ-025 Reset asserted during ROUND or FINAL SHALL abort the block with no done pulse. After release, the block SHALL wait for a fresh start.

Structure
REQ-026 The 64-entry K constant table, the state enum, and the SHA-256 initial hash H0 values SHALL live in shared package miner_core_pkg.
REQ-027 One combinational sub-module, miner_core_round (a..h, w, k in; next a..h out), SHALL hold the round function.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Padded "abc" block (w expanded by the miner_core_msa model) with hash_in = standard H0 -> hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Latency check -> done high exactly 65 edges after the start edge, busy high for exactly 65 cycles, and done is a single-cycle pulse.
- Chaining: first block of the 56-byte string "abcdbcdecdefghijklm...nopq", then hash_out fed back as hash_in with the padding block -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- start pulsed at round t=30 -> ignored; result still matches the "abc" digest.
- n_rst pulsed low at t=40 -> outputs zero immediately, no done pulse; a subsequent "abc" run passes.
- w all zeros, hash_in all zeros -> hash_out matches the golden model, and an all-zero-wrap edge case shows no X propagation.

Source files
------------

// File: rtl/miner_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miner_core_pkg: shared SHA-256 constants, FSM states, round helpers  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package miner_core_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef logic [0:7][31:0] hash_t;

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam hash_t H0 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage
`default_nettype wire

// File: rtl/miner_core_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miner_core_round: one combinational SHA-256 compression round        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module miner_core_round
   import miner_core_pkg::*;
(
   input  logic [0:7][31:0] state_in,
   input  logic [31:0]      w,
   input  logic [31:0]      k,
   output logic [0:7][31:0] state_out
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = state_in[7] + big_sigma1(state_in[4])
         + ch(state_in[4], state_in[5], state_in[6]) + k + w;
      t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
      state_out[0] = t1 + t2;
      state_out[1] = state_in[0];
      state_out[2] = state_in[1];
      state_out[3] = state_in[2];
      state_out[4] = state_in[3] + t1;
      state_out[5] = state_in[4];
      state_out[6] = state_in[5];
      state_out[7] = state_in[6];
   end

endmodule
`default_nettype wire

// File: rtl/miner_core_compress.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | miner_core_compress: iterative SHA-256 block compression, 1 round/clk |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module miner_core_compress
   import miner_core_pkg::*;
#(
   parameter int ROUNDS = 64   // only 64 is meaningful for SHA-256
)
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [0:63][0:31] w,
   input  logic [0:7][0:31]  hash_in,
   output logic             busy,
   output logic             done,
   output logic [0:7][0:31]  hash_out
);

   localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

   state_e          state_q, state_d;
   logic [6:0]      t_q, t_d;
   logic [0:7][31:0] work_q, work_d;
   logic [0:7][31:0] h_save_q, h_save_d;
   logic [0:7][31:0] hash_out_q, hash_out_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [31:0]      w_cur;
   logic [0:7][31:0] round_out;

   // w is held stable by the producer for the whole block, so index it live
   assign w_cur = w[t_q[5:0]];

   miner_core_round u_round (
      .state_in  (work_q),
      .w         (w_cur),
      .k         (K[t_q[5:0]]),
      .state_out (round_out)
   );

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      work_d     = work_q;
      h_save_d   = h_save_q;
      hash_out_d = hash_out_q;
      busy_d     = busy_q;
      done_d     = done_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d   = hash_in;
               h_save_d = hash_in;
               t_d      = 7'd0;
               busy_d   = 1'b1;
               state_d  = ST_ROUND;
            end
         end
         ST_ROUND: begin
            work_d = round_out;
            t_d    = t_q + 7'd1;
            if (t_q == LAST_T) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            for (int i = 0; i < 8; i++) begin
               hash_out_d[i] = h_save_q[i] + work_q[i];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         t_q        <= 7'd0;
         work_q     <= '0;
         h_save_q   <= '0;
         hash_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         work_q     <= work_d;
         h_save_q   <= h_save_d;
         hash_out_q <= hash_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hash_out = hash_out_q;

endmodule
`default_nettype wire

// File: tb/tb_miner_core_compress.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_miner_core_compress: vectors, random blocks and corner sequences  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_miner_core_compress;

   typedef logic [0:63][31:0] sched_t;
   typedef logic [0:15][31:0] blk_t;
   typedef logic [0:7][31:0]  hash_t;

   typedef struct {
      string name;
      sched_t wv;
      hash_t  hv;
      hash_t  exp;
   } vec_t;

   localparam hash_t STD_H0 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam hash_t ABC_DIGEST = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam hash_t CHAIN_DIGEST = {
      32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

   logic             clk = 1'b0;
   logic             n_rst;
   logic             start;
   logic [0:63][0:31] w;
   logic [0:7][0:31]  hash_in;
   logic             busy;
   logic             done;
   logic [0:7][0:31]  hash_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] k_tab [64];

   always #5 clk = ~clk;

   miner_core_compress #(.ROUNDS(64)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .w        (w),
      .hash_in  (hash_in),
      .busy     (busy),
      .done     (done),
      .hash_out (hash_out)
   );

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // K[t] = first 32 fractional bits of the cube root of the t-th prime
   task automatic init_consts();
      int primes [64];
      int n;
      real x;
      real fr;
      n = 0;
      for (int p = 2; n < 64; p++) begin
         bit isp;
         isp = 1'b1;
         for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
         if (isp) begin
            primes[n] = p;
            n++;
         end
      end
      for (int i = 0; i < 64; i++) begin
         x  = $pow(real'(primes[i]), 1.0 / 3.0);
         x  = x - (x * x * x - real'(primes[i])) / (3.0 * x * x);
         fr = x - $floor(x);
         k_tab[i] = 32'(longint'($floor(fr * 4294967296.0)));
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sched_t expand(input blk_t m);
      sched_t s;
      logic [31:0] s0, s1;
      for (int t = 0; t < 16; t++) s[t] = m[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(s[t-15], 7) ^ rr(s[t-15], 18) ^ (s[t-15] >> 3);
         s1 = rr(s[t-2], 17) ^ rr(s[t-2], 19) ^ (s[t-2] >> 10);
         s[t] = s[t-16] + s0 + s[t-7] + s1;
      end
      return s;
   endfunction

   function automatic hash_t model_compress(input sched_t wv, input hash_t hv);
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      hash_t r;
      for (int i = 0; i < 8; i++) v[i] = hv[i];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + wv[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[i] = hv[i] + v[i];
      return r;
   endfunction

   // start_at / rst_at are edge counts after the start edge (E0 counts as 1)
   task automatic run_block(input sched_t wv, input hash_t hv, input int start_at,
                            input int rst_at, input bit start_in_done,
                            output hash_t res);
      int cnt;
      int busy_cnt;
      int seen;
      bit aborted;
      res = '0;
      aborted = 1'b0;
      @(negedge clk);
      w = wv;
      hash_in = hv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 1;
      busy_cnt = 0;
      while (!done && cnt < 150) begin
         if (busy) busy_cnt++;
         if (cnt == rst_at) begin
            n_rst = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_hash_out", hash_out, 0);
            #1 n_rst = 1'b1;
            aborted = 1'b1;
            break;
         end
         start = (cnt == start_at);
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      if (aborted) begin
         seen = 0;
         for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
         end
         check("no_activity_after_reset", seen, 0);
      end else if (!done) begin
         check("done_timeout", 0, 1);
      end else begin
         check("latency_edges", cnt - 1, 65);
         check("busy_cycles", busy_cnt, 65);
         check("busy_at_done", busy, 0);
         res = hash_out;
         if (start_in_done) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("done_single_pulse", done, 0);
         check("hash_out_hold", hash_out, res);
         if (start_in_done) check("start_in_done_ignored", busy, 0);
      end
   endtask

   initial begin
      vec_t   tbl [3];
      blk_t   m_abc, m1, m2;
      hash_t  res, res1, exp;
      sched_t rw;
      hash_t  rh;

      init_consts();
      n_rst = 1'b0;
      start = 1'b0;
      w = '0;
      hash_in = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hash_out", hash_out, 0);
      n_rst = 1'b1;

      m_abc = '0;
      m_abc[0] = 32'h61626380;
      m_abc[15] = 32'h00000018;

      tbl[0] = '{name: "abc", wv: expand(m_abc), hv: STD_H0, exp: ABC_DIGEST};
      tbl[1] = '{name: "all_zero", wv: '0, hv: '0, exp: model_compress('0, '0)};
      tbl[2] = '{name: "all_ones_wrap", wv: '1, hv: '1, exp: model_compress('1, '1)};

      for (int i = 0; i < 3; i++) begin
         run_block(tbl[i].wv, tbl[i].hv, -1, -1, 1'b0, res);
         check(tbl[i].name, res, tbl[i].exp);
         check("no_x_result", 256'($isunknown(res)), 0);
      end

      // two-block message, second block chained straight from hash_out
      m1 = '0;
      for (int i = 0; i < 14; i++)
         for (int j = 0; j < 4; j++)
            m1[i][31 - 8*j -: 8] = 8'(8'h61 + i + j);
      m1[14] = 32'h80000000;
      m2 = '0;
      m2[15] = 32'h000001c0;
      run_block(expand(m1), STD_H0, -1, -1, 1'b0, res1);
      check("chain_block1", res1, model_compress(expand(m1), STD_H0));
      run_block(expand(m2), hash_out, -1, -1, 1'b0, res);
      check("chain_digest", res, CHAIN_DIGEST);

      // start pulse at round 30 and again in DONE
      run_block(expand(m_abc), STD_H0, 31, -1, 1'b1, res);
      check("abc_with_mid_start", res, ABC_DIGEST);

      // reset at round 40, then a clean run
      run_block(expand(m_abc), STD_H0, -1, 41, 1'b0, res);
      run_block(expand(m_abc), STD_H0, -1, -1, 1'b0, res);
      check("abc_after_reset", res, ABC_DIGEST);

      for (int n = 0; n < 6; n++) begin
         for (int t = 0; t < 64; t++) rw[t] = $urandom;
         for (int i = 0; i < 8; i++) rh[i] = $urandom;
         exp = model_compress(rw, rh);
         run_block(rw, rh, -1, -1, 1'b0, res);
         check("random_block", res, exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
